// File: rtl/fifo_rd_checker_if.sv
// Read-side FIFO handshake between the checker (master) and the FIFO (slave).
interface fifo_rd_checker_if #(
  parameter int unsigned DATA_W = 8
);
  logic              rd_full;
  logic              rd_empty;
  logic [DATA_W-1:0] rd_data;
  logic              rd_req;

  modport master (
    output rd_req,
    input  rd_full,
    input  rd_empty,
    input  rd_data
  );

  modport slave (
    input  rd_req,
    output rd_full,
    output rd_empty,
    output rd_data
  );
endinterface

// File: rtl/fifo_rd_checker.sv
// fifo_rd_checker: waits for the FIFO to report full, drains it in one burst and
// checks each word against an incrementing ramp that restarts at zero every
// burst. Reports burst length, a saturating mismatch count and a pass flag.
module fifo_rd_checker #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_rd_checker_if.master    rd_if,
  output logic                 burst_done_o,
  output logic [LEN_W-1:0]     burst_len_o,
  output logic [15:0]          err_cnt_o,
  output logic                 len_err_o,
  output logic                 pass_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Drain counter only has to count up to RD_LATENCY-1.
  localparam int unsigned      DRAIN_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LATENCY - 1);
  localparam logic [LEN_W-1:0]   DEPTH_L    = LEN_W'(DEPTH);

  // Saturating increment of the 16-bit mismatch counter.
  function automatic logic [15:0] sat_inc_err(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  // Saturating increment of the word counter.
  function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
    logic [LEN_W-1:0] r;
    if (v == {LEN_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(LEN_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [DRAIN_W-1:0]      drain_q, drain_d;
  logic [RD_LATENCY-1:0]   vld_q, vld_d;
  logic [DATA_W-1:0]       exp_q, exp_d;
  logic [LEN_W-1:0]        word_cnt_q, word_cnt_d;
  logic                    burst_done_q, burst_done_d;
  logic [LEN_W-1:0]        burst_len_q, burst_len_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic                    len_err_q, len_err_d;
  logic                    pass_q, pass_d;

  logic                    rd_req_t_s;
  logic                    rd_req_s;
  logic                    start_s;
  logic                    enter_done_s;
  logic                    tail_s;
  logic                    mismatch_s;

  // Read request is gated by empty so an underflow read is never issued.
  assign rd_req_s     = rd_req_t_s & ~rd_if.rd_empty;
  assign rd_if.rd_req = rd_req_s;
  assign tail_s       = vld_q[RD_LATENCY-1];
  assign mismatch_s   = tail_s & (rd_if.rd_data != exp_q);

  // Burst FSM next-state: wait for full, read to empty, let reads land, report.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    rd_req_t_s   = 1'b0;
    start_s      = 1'b0;
    enter_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        drain_d = '0;
        // Empty overrides full: nothing to read, so stay put.
        if (rd_if.rd_full && !rd_if.rd_empty) begin
          state_d = ST_READ;
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        rd_req_t_s = 1'b1;
        // Full dropping mid-burst is ignored; only empty ends the burst.
        if (rd_if.rd_empty) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d      = ST_DONE;
          drain_d      = '0;
          enter_done_s = 1'b1;
        end else begin
          state_d = ST_DRAIN;
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        drain_d = '0;
      end
    endcase
  end

  // Data path next-state: valid pipeline, word count, ramp check and status.
  always_comb begin
    vld_d        = '0;
    exp_d        = exp_q;
    word_cnt_d   = word_cnt_q;
    err_cnt_d    = err_cnt_q;
    burst_done_d = enter_done_s;
    burst_len_d  = burst_len_q;
    len_err_d    = len_err_q;
    pass_d       = pass_q;

    vld_d[0] = rd_req_s;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      vld_d[i] = vld_q[i-1];
    end

    if (start_s) begin
      exp_d      = '0;
      word_cnt_d = '0;
    end else begin
      if (rd_req_s) begin
        word_cnt_d = sat_inc_len(word_cnt_q);
      end else begin
        word_cnt_d = word_cnt_q;
      end
      // A mismatch resyncs the ramp to the received word.
      if (mismatch_s) begin
        err_cnt_d = sat_inc_err(err_cnt_q);
        exp_d     = rd_if.rd_data + DATA_W'(1);
      end else if (tail_s) begin
        exp_d = exp_q + DATA_W'(1);
      end else begin
        exp_d = exp_q;
      end
    end

    if (enter_done_s) begin
      burst_len_d = word_cnt_q;
      len_err_d   = len_err_q | (word_cnt_q != DEPTH_L);
      pass_d      = (err_cnt_d == 16'd0) && !len_err_d;
    end else if (mismatch_s) begin
      pass_d = 1'b0;
    end else begin
      pass_d = pass_q;
    end
  end

  // FSM state and drain counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Data path and status registers; status holds between bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      exp_q        <= '0;
      word_cnt_q   <= '0;
      burst_done_q <= 1'b0;
      burst_len_q  <= '0;
      err_cnt_q    <= 16'd0;
      len_err_q    <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      exp_q        <= exp_d;
      word_cnt_q   <= word_cnt_d;
      burst_done_q <= burst_done_d;
      burst_len_q  <= burst_len_d;
      err_cnt_q    <= err_cnt_d;
      len_err_q    <= len_err_d;
      pass_q       <= pass_d;
    end
  end

  assign burst_done_o = burst_done_q;
  assign burst_len_o  = burst_len_q;
  assign err_cnt_o    = err_cnt_q;
  assign len_err_o    = len_err_q;
  assign pass_o       = pass_q;

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Bench for fifo_rd_checker: two DUTs (read latency 1 and 2) fed identical FIFO
// contents by a bench-side FIFO model; a scoreboard of per-burst expectations
// is consumed by a monitor on every burst_done pulse.
module tb_fifo_rd_checker;

  typedef struct {
    int len;
    int err;
    bit len_err;
    bit pass;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_checker_if #(.DATA_W(8)) if0 ();
  fifo_rd_checker_if #(.DATA_W(8)) if1 ();

  logic        done0, done1, lerr0, lerr1, pass0, pass1;
  logic [15:0] blen0, blen1, ecnt0, ecnt1;

  fifo_rd_checker #(.DATA_W(8), .DEPTH(256), .RD_LATENCY(1), .LEN_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rd_if(if0), .burst_done_o(done0), .burst_len_o(blen0),
    .err_cnt_o(ecnt0), .len_err_o(lerr0), .pass_o(pass0));

  fifo_rd_checker #(.DATA_W(8), .DEPTH(256), .RD_LATENCY(2), .LEN_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rd_if(if1), .burst_done_o(done1), .burst_len_o(blen1),
    .err_cnt_o(ecnt1), .len_err_o(lerr1), .pass_o(pass1));

  // ---------------- FIFO model (one per lane, identical contents) ----------------
  logic [7:0] mem [2][0:1023];
  logic [9:0] wp [2];
  logic [9:0] rp [2] = '{10'd0, 10'd0};
  logic [7:0] data0_r = 8'd0;
  logic [7:0] pipe1_r = 8'd0;
  logic [7:0] data1_r = 8'd0;
  logic       force_full = 1'b0;

  assign if0.rd_empty = (wp[0] == rp[0]);
  assign if1.rd_empty = (wp[1] == rp[1]);
  assign if0.rd_full  = force_full | (10'(wp[0] - rp[0]) == 10'd256);
  assign if1.rd_full  = force_full | (10'(wp[1] - rp[1]) == 10'd256);
  assign if0.rd_data  = data0_r;
  assign if1.rd_data  = data1_r;

  // Accepted reads pop the FIFO; otherwise the q output carries junk.
  always @(posedge clk) begin
    if (if0.rd_req) begin
      data0_r <= mem[0][rp[0]];
      rp[0]   <= rp[0] + 10'd1;
    end else begin
      data0_r <= 8'($urandom);
    end
    if (if1.rd_req) begin
      pipe1_r <= mem[1][rp[1]];
      rp[1]   <= rp[1] + 10'd1;
    end else begin
      pipe1_r <= 8'($urandom);
    end
    data1_r <= pipe1_r;
  end

  // ---------------- scoreboard and reference model ----------------
  exp_t       exp_q[$];
  logic [7:0] words[$];
  int         m_err;
  bit         m_len_err;
  int         done_idx [2];
  int         n_checks = 0;
  int         n_errors = 0;
  int         tmo_cnt  = 0;
  bit         end_req  = 1'b0;
  bit         end_ack  = 1'b0;

  function automatic void chk(input string name, input int lane, input longint act, input longint want);
    n_checks++;
    if (act != want) begin
      n_errors++;
      $display("FAIL %s lane%0d: got %0d expected %0d", name, lane, act, want);
    end
  endfunction

  task automatic make_ramp(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(8'(i));
  endtask

  task automatic load_words();
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < words.size(); i++) mem[l][10'(wp[l] + 10'(i))] = words[i];
      wp[l] = 10'(wp[l] + 10'(words.size()));
    end
    force_full = (words.size() < 256);
  endtask

  // Reference: a word is an error when it does not continue the previous word
  // (the first word must be 0). Totals are cumulative since reset.
  task automatic push_expect();
    int n;
    int e;
    logic [7:0] want;
    exp_t r;
    n = words.size();
    e = 0;
    for (int i = 0; i < n; i++) begin
      want = (i == 0) ? 8'd0 : 8'(words[i-1] + 8'd1);
      if (words[i] != want) e++;
    end
    m_err     = (m_err + e > 65535) ? 65535 : m_err + e;
    m_len_err = m_len_err | (n != 256);
    r.len     = n;
    r.err     = m_err;
    r.len_err = m_len_err;
    r.pass    = (m_err == 0) && !m_len_err;
    exp_q.push_back(r);
  endtask

  task automatic wait_all_done(input int target);
    int t;
    t = 0;
    while ((done_idx[0] < target || done_idx[1] < target) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) tmo_cnt++;
    force_full = 1'b0;
  endtask

  task automatic run_burst();
    load_words();
    push_expect();
    wait_all_done(exp_q.size());
  endtask

  // ---------------- monitor ----------------
  logic       ln_done [2];
  logic       ln_req  [2];
  logic       ln_empty[2];
  logic       ln_le   [2];
  logic       ln_ps   [2];
  logic [15:0] ln_len [2];
  logic [15:0] ln_err [2];
  assign ln_done[0] = done0;  assign ln_done[1] = done1;
  assign ln_req[0]  = if0.rd_req;   assign ln_req[1]  = if1.rd_req;
  assign ln_empty[0] = if0.rd_empty; assign ln_empty[1] = if1.rd_empty;
  assign ln_le[0] = lerr0;  assign ln_le[1] = lerr1;
  assign ln_ps[0] = pass0;  assign ln_ps[1] = pass1;
  assign ln_len[0] = blen0; assign ln_len[1] = blen1;
  assign ln_err[0] = ecnt0; assign ln_err[1] = ecnt1;

  initial begin : monitor
    int   cyc;
    int   tmo_seen;
    int   last_acc [2];
    bit   prev_dn  [2];
    exp_t r;
    cyc = 0;
    tmo_seen = 0;
    last_acc[0] = 0; last_acc[1] = 0;
    prev_dn[0] = 1'b0; prev_dn[1] = 1'b0;
    done_idx[0] = 0; done_idx[1] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int l = 0; l < 2; l++) begin
        if (!rst_n) begin
          chk("reset_ctl", l, {ln_req[l], ln_done[l], ln_le[l], ln_ps[l]}, 0);
          chk("reset_burst_len", l, ln_len[l], 0);
          chk("reset_err_cnt", l, ln_err[l], 0);
          prev_dn[l] = 1'b0;
        end else begin
          if (ln_empty[l]) chk("rd_req_gate", l, ln_req[l], 0);
          if (ln_done[l]) begin
            chk("done_width", l, prev_dn[l], 0);
            if (done_idx[l] < exp_q.size()) begin
              r = exp_q[done_idx[l]];
              chk("burst_len", l, ln_len[l], r.len);
              chk("err_cnt", l, ln_err[l], r.err);
              chk("len_err", l, ln_le[l], r.len_err);
              chk("pass", l, ln_ps[l], r.pass);
              chk("done_latency_ok", l, ((cyc - last_acc[l]) >= (l + 3)) ? 1 : 0, 1);
            end else begin
              chk("unexpected_done", l, done_idx[l] + 1, exp_q.size());
            end
            done_idx[l]++;
          end
          if (ln_req[l]) last_acc[l] = cyc;
          prev_dn[l] = ln_done[l];
        end
      end
      if (tmo_cnt != tmo_seen) begin
        chk("wait_timeout", 0, tmo_cnt, tmo_seen);
        tmo_seen = tmo_cnt;
      end
      if (end_req && !end_ack) begin
        for (int l = 0; l < 2; l++) chk("burst_count", l, done_idx[l], exp_q.size());
        end_ack = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int         n;
    int         pos;
    int         t;
    logic [9:0] st;
    wp[0] = 10'd0;
    wp[1] = 10'd0;
    m_err = 0;
    m_len_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean full burst, then three more clean bursts back to back.
    make_ramp(256); run_burst();
    repeat (3) begin make_ramp(256); run_burst(); end

    // Ramp jumps to 8'hAA at word 10 and continues from there.
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back(8'((i < 10) ? i : 160 + i));
    run_burst();
    make_ramp(256); run_burst();

    // Short burst: 200 words with full forced.
    make_ramp(200); run_burst();

    // Randomized bursts: random length, optional corrupted word.
    repeat (4) begin
      n = ($urandom_range(1, 0) == 1) ? 256 : int'($urandom_range(255, 120));
      make_ramp(n);
      if ($urandom_range(1, 0) == 1) begin
        pos = int'($urandom_range(n - 1, 0));
        words[pos] = 8'($urandom);
      end
      run_burst();
    end

    // Reset in the middle of a burst after 50 words.
    make_ramp(256);
    load_words();
    st = rp[0];
    t = 0;
    while (10'(rp[0] - st) < 10'd50 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) tmo_cnt++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    wp[0] = rp[0];
    wp[1] = rp[1];
    m_err = 0;
    m_len_err = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    make_ramp(256); run_burst();
    repeat (2) begin
      make_ramp(256);
      pos = int'($urandom_range(255, 0));
      words[pos] = 8'($urandom);
      run_burst();
    end

    // Full and empty together: no read, no burst.
    force_full = 1'b1;
    repeat (20) @(negedge clk);
    force_full = 1'b0;

    repeat (10) @(negedge clk);
    end_req = 1'b1;
    t = 0;
    while (!end_ack && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!end_ack) begin
      n_checks++;
      n_errors++;
      $display("FAIL end_handshake lane0: got 0 expected 1");
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
